// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one iteration per clock, with fast paths for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          op_q;
    logic                neg_q;     // product / quotient sign
    logic                neg_r;     // remainder sign
    logic [2*XLEN-1:0]   acc;       // product or partial remainder
    logic [2*XLEN-1:0]   x;         // shifting multiplicand or dividend
    logic [XLEN-1:0]     y;         // shifting multiplier or quotient being built
    logic [XLEN-1:0]     dvs;

    // Operand decode for the cycle start is seen in IDLE.
    logic            a_sgn, b_sgn;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] fast_res;

    assign a_sgn    = a[XLEN-1] & (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    assign b_sgn    = b[XLEN-1] & (op == OP_MULH || op == OP_DIV || op == OP_REM);
    assign a_mag    = a_sgn ? -a : a;
    assign b_mag    = b_sgn ? -b : b;
    assign div_zero = op[2] && (b == '0);
    assign div_ovf  = op[2] && !op[0] && (a == INT_MIN) && (b == '1);
    assign fast_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : INT_MIN);

    // One datapath step, shared by multiply and divide.
    logic [2*XLEN-1:0] acc_nx, x_nx, rem_sh;
    logic [XLEN-1:0]   y_nx;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_nx = acc;
        x_nx   = x << 1;
        y_nx   = y;
        rem_sh = '0;
        if (op_q[2]) begin
            rem_sh = {acc[2*XLEN-2:0], x[XLEN-1]};
            if (rem_sh >= {{XLEN{1'b0}}, dvs}) begin
                acc_nx = rem_sh - {{XLEN{1'b0}}, dvs};
                y_nx   = {y[XLEN-2:0], 1'b1};
            end else begin
                acc_nx = rem_sh;
                y_nx   = {y[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nx = acc + (y[0] ? x : '0);
            y_nx   = y >> 1;
        end
    end

    // Sign fix-up happens once, on the value produced by the final iteration.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, final_res;

    always_comb begin
        prod = neg_q ? -acc_nx : acc_nx;
        quo  = neg_q ? -y_nx : y_nx;
        rmd  = neg_r ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
        if (op_q[2])
            final_res = op_q[1] ? rmd : quo;
        else
            final_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    assign busy  = (state != IDLE);
    assign stall = (state == IDLE && start) || (state == CALC);

    // NOTE: sequential state uses non-blocking assignments only; the async reset
    // also clears the datapath registers so an aborted operation leaves no residue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            x      <= '0;
            y      <= '0;
            dvs    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        neg_q <= a_sgn ^ b_sgn;
                        neg_r <= a_sgn;
                        cnt   <= '0;
                        acc   <= '0;
                        x     <= {{XLEN{1'b0}}, a_mag};
                        y     <= op[2] ? '0 : b_mag;
                        dvs   <= b_mag;
                        if (div_zero || div_ovf) begin
                            result <= fast_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nx;
                    x   <= x_nx;
                    y   <= y_nx;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN-1)) begin
                        result <= final_res;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a reference model pushes expected results at
// issue time, and a done-monitor pops and compares them.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, stall, done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx, sy, zx, zy, p;
        int ix, iy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        zx = {32'b0, x};
        zy = {32'b0, y};
        ix = x;
        iy = y;
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * zy; return p[63:32]; end
            3'd3: begin p = zx * zy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ix / iy);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ix % iy);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    // Compares every result the DUT delivers against the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check(e.tag, result, e.val);
            end
        end
    end

    task automatic issue(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int lat, cyc, stalls;
        lat = exp_latency(o, x, y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        push_exp(tag, model(o, x, y));
        #1;
        stalls = (stall === 1'b1) ? 1 : 0;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        #1;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            if (stall === 1'b1) stalls++;
            @(negedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(lat));
        check({tag, "_stall_at_done"}, 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : main
        int cyc;
        logic [2:0]  ro;
        logic [31:0] ra, rb, held;

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        #1;
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_stall",  32'(stall),  32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", result,      32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue("mul_7x6",       3'd0, 32'd7, 32'd6);
        issue("mulh_m1x2",     3'd1, 32'hFFFF_FFFF, 32'd2);
        issue("mulhu_m1x2",    3'd3, 32'hFFFF_FFFF, 32'd2);
        issue("mulhsu_m1xmax", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue("div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'd2);
        issue("rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'd2);
        issue("divu_big_2",    3'd5, 32'hFFFF_FFF9, 32'd2);
        issue("divu_by0",      3'd5, 32'd123, 32'd0);
        issue("rem_by0",       3'd6, 32'd123, 32'd0);
        issue("div_ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue("rem_ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        issue("remu_big",      3'd7, 32'hDEAD_BEEF, 32'd1000);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        op = 3'd4; a = 32'hFFFF_FF9C; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        check("busy_before_rst", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy",   32'(busy),  32'd0);
        check("midrst_stall",  32'(stall), 32'd0);
        check("midrst_done",   32'(done),  32'd0);
        check("midrst_result", result,     32'd0);
        #3;
        rst = 1'b0;
        issue("mul_3x5_after_rst", 3'd0, 32'd3, 32'd5);

        // Start pulses during CALC must be ignored.
        @(negedge clk);
        op = 3'd4; a = 32'd1000; b = 32'd7; start = 1'b1;
        push_exp("div_busy_ignore", model(3'd4, 32'd1000, 32'd7));
        held = model(3'd4, 32'd1000, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        op = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("busy_ignore_done_seen", 32'(done), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("hold_result_%0d", i), result, held);
            check($sformatf("hold_idle_%0d", i), 32'({busy, done}), 32'd0);
        end

        // A few random operations, with divide-by-zero and overflow mixed in.
        for (int i = 0; i < 10; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) rb = 32'd0;
            if (i == 6) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            issue($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
